// File: rtl/parking_lot_monitor.sv
// Parking lot occupancy monitor.
// Two beam sensors (outer = street side, inner = lot side) are synchronized, a
// direction-detect FSM recognises complete entry/exit sequences, and a saturating
// counter tracks occupancy.
// Optional feature macro: PARKING_OCCUPANCY_FLAGS_EN drives full/empty from the count;
// without it both flags are tied to 0.
module parking_lot_monitor #(
  parameter int unsigned CAPACITY    = 25,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       outer,
  input  logic       inner,
  output logic [4:0] count,
  output logic       enter,
  output logic       exit,
  output logic       full,
  output logic       empty
);

  localparam logic [4:0] CapW = 5'(CAPACITY);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StEn1  = 3'd1;
  localparam logic [2:0] StEn2  = 3'd2;
  localparam logic [2:0] StEn3  = 3'd3;
  localparam logic [2:0] StEx1  = 3'd4;
  localparam logic [2:0] StEx2  = 3'd5;
  localparam logic [2:0] StEx3  = 3'd6;

  logic [SYNC_STAGES-1:0] r_outer_sync;
  logic [SYNC_STAGES-1:0] r_inner_sync;
  logic [1:0]             w_pat;
  logic [2:0]             r_state;
  logic [2:0]             w_state_d;
  logic                   w_enter_d;
  logic                   w_exit_d;
  logic                   r_enter;
  logic                   r_exit;
  logic [4:0]             r_count;

  // Shift raw sensor levels through the synchronizer chains.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_outer_sync <= '0;
      r_inner_sync <= '0;
    end else begin
      r_outer_sync <= {r_outer_sync[SYNC_STAGES-2:0], outer};
      r_inner_sync <= {r_inner_sync[SYNC_STAGES-2:0], inner};
    end
  end

  // Only the last synchronizer stage is safe to decode: {outer_s, inner_s}.
  assign w_pat = {r_outer_sync[SYNC_STAGES-1], r_inner_sync[SYNC_STAGES-1]};

  // Next-state and pulse decode; unlisted patterns hold the current state.
  always_comb begin
    w_state_d = r_state;
    w_enter_d = 1'b0;
    w_exit_d  = 1'b0;
    case (r_state)
      StIdle: begin
        // 11 from idle is ambiguous and ignored.
        if (w_pat == 2'b10)      w_state_d = StEn1;
        else if (w_pat == 2'b01) w_state_d = StEx1;
      end
      StEn1: begin
        if (w_pat == 2'b11)                          w_state_d = StEn2;
        else if (w_pat == 2'b00 || w_pat == 2'b01)   w_state_d = StIdle;
      end
      StEn2: begin
        if (w_pat == 2'b01)      w_state_d = StEn3;
        else if (w_pat == 2'b10) w_state_d = StEn1;  // car backs up
        else if (w_pat == 2'b00) w_state_d = StIdle;
      end
      StEn3: begin
        if (w_pat == 2'b00) begin
          w_state_d = StIdle;
          w_enter_d = 1'b1;
        end else if (w_pat == 2'b11) begin
          w_state_d = StEn2;
        end else if (w_pat == 2'b10) begin
          w_state_d = StIdle;
        end
      end
      StEx1: begin
        if (w_pat == 2'b11)                          w_state_d = StEx2;
        else if (w_pat == 2'b00 || w_pat == 2'b10)   w_state_d = StIdle;
      end
      StEx2: begin
        if (w_pat == 2'b10)      w_state_d = StEx3;
        else if (w_pat == 2'b01) w_state_d = StEx1;
        else if (w_pat == 2'b00) w_state_d = StIdle;
      end
      StEx3: begin
        if (w_pat == 2'b00) begin
          w_state_d = StIdle;
          w_exit_d  = 1'b1;
        end else if (w_pat == 2'b11) begin
          w_state_d = StEx2;
        end else if (w_pat == 2'b01) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // FSM state and registered one-cycle pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= StIdle;
      r_enter <= 1'b0;
      r_exit  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_enter <= w_enter_d;
      r_exit  <= w_exit_d;
    end
  end

  // Saturating occupancy counter, driven by the registered pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (r_enter && (r_count < CapW)) begin
      r_count <= r_count + 5'd1;
    end else if (r_exit && (r_count != 5'd0)) begin
      r_count <= r_count - 5'd1;
    end
  end

  assign count = r_count;
  assign enter = r_enter;
  assign exit  = r_exit;

  // Occupancy flags decoded straight from the count register.
`ifdef PARKING_OCCUPANCY_FLAGS_EN
  always_comb begin
    full  = (r_count == CapW);
    empty = (r_count == 5'd0);
  end
`else
  always_comb begin
    full  = 1'b0;
    empty = 1'b0;
  end
`endif

endmodule

// File: tb/tb_parking_lot_monitor.sv
// Self-checking bench for parking_lot_monitor: table-driven sequences, hand-written
// latency/reset/saturation cases and random traffic, all compared every cycle against
// a path-position reference model.
module tb_parking_lot_monitor;

  localparam int unsigned CAP  = 25;
  localparam int unsigned SYNC = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       outer = 1'b0;
  logic       inner = 1'b0;
  logic [4:0] count;
  logic       enter;
  logic       exit_p;
  logic       full;
  logic       empty;

  always #5 clk = ~clk;

  parking_lot_monitor #(
    .CAPACITY    (CAP),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .outer (outer),
    .inner (inner),
    .count (count),
    .enter (enter),
    .exit  (exit_p),
    .full  (full),
    .empty (empty)
  );

  int errors = 0;
  int checks = 0;
  int n_enter = 0;
  int n_exit = 0;

  // Reference model: raw samples delayed by SYNC edges, then tracked as a position
  // along the expected entry (+1) or exit (-1) path.
  logic [1:0] m_sync [SYNC];
  int         m_dir;
  int         m_step;
  logic       m_enter;
  logic       m_exit;
  int         m_count;

  function automatic logic [1:0] path_pat(input int dir, input int idx);
    logic [1:0] p [4];
    if (dir > 0) p = '{2'b10, 2'b11, 2'b01, 2'b00};
    else         p = '{2'b01, 2'b11, 2'b10, 2'b00};
    return p[idx];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < SYNC; i++) m_sync[i] = 2'b00;
    m_dir = 0; m_step = 0; m_enter = 1'b0; m_exit = 1'b0; m_count = 0;
  endtask

  task automatic model_edge(input logic [1:0] raw);
    int         nc;
    logic [1:0] s;
    logic       ne;
    logic       nx;
    nc = m_count;
    if (m_enter && nc < int'(CAP)) nc++;
    else if (m_exit && nc > 0) nc--;
    s = m_sync[SYNC-1];
    ne = 1'b0; nx = 1'b0;
    if (m_dir == 0) begin
      if (s == 2'b10)      begin m_dir = 1;  m_step = 1; end
      else if (s == 2'b01) begin m_dir = -1; m_step = 1; end
    end else if (s == path_pat(m_dir, m_step)) begin
      if (m_step == 3) begin
        if (m_dir > 0) ne = 1'b1; else nx = 1'b1;
        m_dir = 0; m_step = 0;
      end else begin
        m_step++;
      end
    end else if (s == path_pat(m_dir, m_step - 1)) begin
      // still on the same beam pattern
    end else if (m_step >= 2 && s == path_pat(m_dir, m_step - 2)) begin
      m_step--;
    end else begin
      m_dir = 0; m_step = 0;
    end
    for (int i = SYNC - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
    m_sync[0] = raw;
    m_count = nc; m_enter = ne; m_exit = nx;
  endtask

  function automatic logic exp_full();
`ifdef PARKING_OCCUPANCY_FLAGS_EN
    return m_count == int'(CAP);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic exp_empty();
`ifdef PARKING_OCCUPANCY_FLAGS_EN
    return m_count == 0;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check_int(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic compare_model();
    checks++;
    if (int'(count) != m_count || enter !== m_enter || exit_p !== m_exit ||
        full !== exp_full() || empty !== exp_empty() || (enter && exit_p)) begin
      errors++;
      $display("FAIL model t=%0t: count=%0d enter=%0b exit=%0b full=%0b empty=%0b, expected count=%0d enter=%0b exit=%0b full=%0b empty=%0b",
               $time, count, enter, exit_p, full, empty, m_count, m_enter, m_exit,
               exp_full(), exp_empty());
    end
  endtask

  // Called at a negedge: drive inputs, advance one edge, compare at the next negedge.
  task automatic tick(input logic [1:0] p);
    {outer, inner} = p;
    @(posedge clk);
    model_edge(p);
    @(negedge clk);
    n_enter += int'(enter);
    n_exit  += int'(exit_p);
    compare_model();
  endtask

  task automatic apply_seq(input logic [1:0] seq [4], input int len, input int hold);
    for (int i = 0; i < len; i++)
      for (int h = 0; h < hold; h++) tick(seq[i]);
    for (int t = 0; t < 6; t++) tick(2'b00);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    {outer, inner} = 2'b00;
    model_reset();
    #1;
    check_int("reset_count", int'(count), 0);
    check_int("reset_enter", int'(enter), 0);
    check_int("reset_exit", int'(exit_p), 0);
    check_int("reset_empty", int'(empty), int'(exp_empty()));
    check_int("reset_full", int'(full), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  typedef struct {
    logic [1:0] seq [4];
    int         len;
    int         exp_en;
    int         exp_ex;
    int         exp_count;
  } vec_t;

  vec_t vecs [9];
  logic [1:0] ent_seq [4];
  logic [1:0] ext_seq [4];

  function automatic vec_t mk(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c,
                              input logic [1:0] d, input int len, input int en, input int ex,
                              input int cnt);
    vec_t v;
    v.seq = '{a, b, c, d};
    v.len = len; v.exp_en = en; v.exp_ex = ex; v.exp_count = cnt;
    return v;
  endfunction

  initial begin
    int en0;
    int ex0;
    int c0;
    ent_seq = '{2'b10, 2'b11, 2'b01, 2'b00};
    ext_seq = '{2'b01, 2'b11, 2'b10, 2'b00};
    // Cumulative count after each record, starting from reset.
    vecs[0] = mk(2'b10, 2'b11, 2'b01, 2'b00, 4, 1, 0, 1);  // entry
    vecs[1] = mk(2'b01, 2'b11, 2'b10, 2'b00, 4, 0, 1, 0);  // exit
    vecs[2] = mk(2'b10, 2'b11, 2'b10, 2'b00, 4, 0, 0, 0);  // backs out
    vecs[3] = mk(2'b10, 2'b00, 2'b00, 2'b00, 2, 0, 0, 0);  // outer blip
    vecs[4] = mk(2'b11, 2'b00, 2'b00, 2'b00, 2, 0, 0, 0);  // ambiguous from idle
    vecs[5] = mk(2'b01, 2'b11, 2'b01, 2'b00, 4, 0, 0, 0);  // aborted exit
    vecs[6] = mk(2'b01, 2'b11, 2'b10, 2'b00, 4, 0, 1, 0);  // exit at 0: no underflow
    vecs[7] = mk(2'b10, 2'b11, 2'b01, 2'b00, 4, 1, 0, 1);  // entry
    vecs[8] = mk(2'b10, 2'b11, 2'b10, 2'b00, 4, 0, 0, 1);  // abort keeps count

    do_reset();
    @(negedge clk);
    compare_model();

    // Table-driven sequences, each level held 3 cycles.
    foreach (vecs[i]) begin
      en0 = n_enter; ex0 = n_exit;
      apply_seq(vecs[i].seq, vecs[i].len, 3);
      check_int($sformatf("vec%0d_enter_pulses", i), n_enter - en0, vecs[i].exp_en);
      check_int($sformatf("vec%0d_exit_pulses", i), n_exit - ex0, vecs[i].exp_ex);
      check_int($sformatf("vec%0d_count", i), int'(count), vecs[i].exp_count);
    end
    check_int("empty_flag_after_exit", int'(empty), int'(exp_empty()));

    // Exact latency: inner falls before edge k -> enter after k+2, count after k+3.
    c0 = int'(count);
    for (int i = 0; i < 3; i++)
      for (int h = 0; h < 3; h++) tick(ent_seq[i]);
    tick(2'b00);  // edge k
    check_int("lat_k_enter", int'(enter), 0);
    tick(2'b00);  // edge k+1
    check_int("lat_k1_enter", int'(enter), 0);
    tick(2'b00);  // edge k+2
    check_int("lat_k2_enter", int'(enter), 1);
    check_int("lat_k2_count", int'(count), c0);
    tick(2'b00);  // edge k+3
    check_int("lat_k3_enter", int'(enter), 0);
    check_int("lat_k3_count", int'(count), c0 + 1);
    for (int t = 0; t < 4; t++) tick(2'b00);

    // Reset mid-sequence with count=3, FSM in the both-beams-blocked entry step.
    apply_seq(ent_seq, 4, 2);
    check_int("pre_reset_count", int'(count), 3);
    for (int h = 0; h < 4; h++) tick(2'b10);
    for (int h = 0; h < 4; h++) tick(2'b11);
    do_reset();
    @(negedge clk);
    compare_model();
    apply_seq(ent_seq, 4, 3);
    check_int("post_reset_entry_count", int'(count), 1);
    apply_seq(ext_seq, 4, 3);

    // Bulk traffic with single-cycle dwell.
    en0 = n_enter; ex0 = n_exit;
    for (int i = 0; i < 16; i++) apply_seq(ent_seq, 4, 1);
    check_int("bulk_count_16", int'(count), 16);
    for (int i = 0; i < 16; i++) apply_seq(ext_seq, 4, 1);
    check_int("bulk_count_0", int'(count), 0);
    check_int("bulk_pulses", (n_enter - en0) + (n_exit - ex0), 32);

    // Saturation at CAPACITY.
    for (int i = 0; i < 26; i++) apply_seq(ent_seq, 4, 1);
    check_int("sat_count", int'(count), int'(CAP));
    check_int("sat_full", int'(full), int'(exp_full()));
    apply_seq(ext_seq, 4, 2);
    check_int("sat_minus_one", int'(count), int'(CAP) - 1);

    // Random traffic mixing complete sequences and noise.
    for (int it = 0; it < 300; it++) begin
      int r;
      int hold;
      r = int'($urandom_range(0, 3));
      hold = int'($urandom_range(1, 3));
      if (r == 0) begin
        for (int i = 0; i < 4; i++)
          for (int h = 0; h < hold; h++) tick(ent_seq[i]);
      end else if (r == 1) begin
        for (int i = 0; i < 4; i++)
          for (int h = 0; h < hold; h++) tick(ext_seq[i]);
      end else begin
        for (int h = 0; h < hold; h++) tick(2'($urandom_range(0, 3)));
      end
    end
    for (int t = 0; t < 6; t++) tick(2'b00);
    check_int("random_final_count", int'(count), m_count);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/parking_lot_monitor.md
Name: parking_lot_monitor

Overview:
- Counts cars in a single-lane parking lot from two beam sensors, `outer` (street side) and `inner` (lot side).
- Each raw sensor passes through a multi-stage flip-flop synchronizer.
- A direction-detect FSM recognises complete entry or exit sequences and produces one-cycle pulses.
- A saturating occupancy counter consumes those pulses; the block sits between the board sensor pins and the display logic.

Parameters:
- CAPACITY, default 25: maximum occupancy; count saturates here. Legal range 1..31.
- SYNC_STAGES, default 2: number of synchronizer flops per sensor input. Minimum 2.

Ports:
- clk    input   1  system clock; all state updates on the rising edge
- reset  input   1  asynchronous, active-low reset
- outer  input   1  raw outer sensor, 1 = beam blocked; asynchronous to clk
- inner  input   1  raw inner sensor, 1 = beam blocked; asynchronous to clk
- count  output  5  current occupancy, 0..CAPACITY
- enter  output  1  one-cycle pulse per completed entry
- exit   output  1  one-cycle pulse per completed exit
- full   output  1  occupancy flag (see Optional Feature)
- empty  output  1  occupancy flag (see Optional Feature)

Behaviour:
- Reset (reset=0, asynchronous):
  - all synchronizer flops go to 0, FSM goes to IDLE.
  - count=0, enter=0, exit=0.
  - reset asserted mid-sequence discards the partial sequence.
- Synchronizer: SYNC_STAGES-deep shift chain per input. Only the last stage feeds the FSM; notation below is {outer_s, inner_s}.
- FSM states: IDLE, EN1, EN2, EN3, EX1, EX2, EX3. Any pattern not listed for a state holds that state.
  - IDLE: 10 -> EN1; 01 -> EX1; 11 stays IDLE (ambiguous, ignored).
  - EN1: 11 -> EN2; 00 or 01 -> IDLE.
  - EN2: 01 -> EN3; 10 -> EN1 (car backs up); 00 -> IDLE.
  - EN3: 00 -> IDLE and assert enter; 11 -> EN2; 10 -> IDLE.
  - EX1: 11 -> EX2; 00 or 10 -> IDLE.
  - EX2: 10 -> EX3; 01 -> EX1; 00 -> IDLE.
  - EX3: 00 -> IDLE and assert exit; 11 -> EX2; 01 -> IDLE.
- enter and exit are registered outputs:
  - each is high for exactly one cycle, set on the same edge the FSM returns to IDLE;
  - the two are never high together.
- Counter, updated on the edge after a pulse:
  - enter and count<CAPACITY: count+1.
  - exit and count>0: count-1.
  - enter at CAPACITY, or exit at 0: ignored, count holds.
  - No wrap-around.
- Latency with SYNC_STAGES=2: raw `inner` falls before edge k (final step of an entry):
  - synchronized value visible after edge k+1;
  - enter high after edge k+2;
  - count updated after edge k+3.
- Sensor levels held for any number of cycles are accepted; there is no minimum dwell time beyond one synchronized sample.

Optional Feature:
- Macro: PARKING_OCCUPANCY_FLAGS_EN.
- Defined:
  - full = (count == CAPACITY), empty = (count == 0);
  - both combinational from the count register;
  - after reset, empty=1 and full=0.
- Not defined: full and empty are tied to constant 0. All other behaviour is identical.

Test Plan:
- Reset: drive reset=0 while count=3 and FSM in EN2 -> immediately count=0, enter=0, exit=0. After release, the first complete entry gives count=1.
- Single entry: outer/inner sequence 00,10,11,01,00, each held 3 cycles -> exactly one enter pulse, exit stays 0, count 0->1 three edges after `inner` falls.
- Single exit from count=1: 01,11,10,00, each held 3 cycles -> one exit pulse, count 1->0, empty=1 when the macro is defined.
- Bulk traffic: 16 back-to-back entries then 16 exits -> count reaches 16, then returns to 0. 32 pulses total, never both pulses in the same cycle.
- Aborts and noise, each ending at 00:
  - 10,11,10,00 -> no pulse;
  - 10,00 -> no pulse;
  - 11,00 from IDLE -> no pulse;
  - 01,11,01,00 -> no pulse;
  - count unchanged in every case.
- Saturation: 26 entries from 0 -> count stops at 25, full=1 (macro defined). At count=0, one exit -> count stays 0, no underflow to 31.
